// File: rtl/alu_div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The div_zero flag exists only when ALU_DIV_ZERO_FLAG_EN is defined.
interface alu_div_seq_if #(
   parameter int WIDTH = 32
);
   logic                    start;
   logic signed [WIDTH-1:0] A;
   logic signed [WIDTH-1:0] B;
   logic signed [WIDTH-1:0] LO;
   logic signed [WIDTH-1:0] HI;
   logic                    busy;
   logic                    done;
`ifdef ALU_DIV_ZERO_FLAG_EN
   logic                    div_zero;

   modport master (output start, A, B, input LO, HI, busy, done, div_zero);
   modport slave  (input start, A, B, output LO, HI, busy, done, div_zero);
`else
   modport master (output start, A, B, input LO, HI, busy, done);
   modport slave  (input start, A, B, output LO, HI, busy, done);
`endif
endinterface

// File: rtl/alu_div_seq.sv
// Multi-cycle signed divider: radix-2 restoring division on magnitudes, sign fix-up,
// quotient to LO and remainder to HI. Optional macro ALU_DIV_ZERO_FLAG_EN adds div_zero.
module alu_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         clear,
   alu_div_seq_if.slave div_if
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic signed [WIDTH-1:0] lo_q, lo_d;
   logic signed [WIDTH-1:0] hi_q, hi_d;
`ifdef ALU_DIV_ZERO_FLAG_EN
   logic                    dz_q, dz_d;
`endif

   logic [WIDTH:0]          rem_q, rem_d;
   logic [WIDTH-1:0]        quo_q, quo_d;
   logic [WIDTH-1:0]        bmag_q, bmag_d;
   logic [WIDTH-1:0]        a_q, a_d;
   logic                    sgn_quo_q, sgn_quo_d;
   logic                    sgn_rem_q, sgn_rem_d;
   logic                    bzero_q, bzero_d;
   logic [WIDTH+1:0]        trial;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic s, input logic [WIDTH-1:0] v);
      return s ? (~v + 1'b1) : v;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      lo_d      = lo_q;
      hi_d      = hi_q;
`ifdef ALU_DIV_ZERO_FLAG_EN
      dz_d      = dz_q;
`endif
      rem_d     = rem_q;
      quo_d     = quo_q;
      bmag_d    = bmag_q;
      a_d       = a_q;
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
      bzero_d   = bzero_q;
      // Shift the next dividend bit into the partial remainder.
      trial     = {rem_q, quo_q[WIDTH-1]};

      case (state_q)
         S_IDLE: begin
            if (div_if.start) begin
               quo_d     = mag(div_if.A);
               bmag_d    = mag(div_if.B);
               a_d       = div_if.A;
               sgn_quo_d = div_if.A[WIDTH-1] ^ div_if.B[WIDTH-1];
               sgn_rem_d = div_if.A[WIDTH-1];
               bzero_d   = (div_if.B == '0);
               rem_d     = '0;
               cnt_d     = '0;
               busy_d    = 1'b1;
`ifdef ALU_DIV_ZERO_FLAG_EN
               dz_d      = 1'b0;
               state_d   = (div_if.B == '0) ? S_FIX : S_RUN;
`else
               state_d   = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (trial >= {2'b00, bmag_q}) begin
               rem_d = (WIDTH+1)'(trial - {2'b00, bmag_q});
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = (WIDTH+1)'(trial);
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            // Divide by zero forces a fixed result independent of operand signs.
            if (bzero_q) begin
               lo_d = '1;
               hi_d = a_q;
`ifdef ALU_DIV_ZERO_FLAG_EN
               dz_d = 1'b1;
`endif
            end else begin
               lo_d = neg_if(sgn_quo_q, quo_q);
               hi_d = neg_if(sgn_rem_q, rem_q[WIDTH-1:0]);
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
`ifdef ALU_DIV_ZERO_FLAG_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
`ifdef ALU_DIV_ZERO_FLAG_EN
         dz_q    <= dz_d;
`endif
      end
   end

   // Datapath registers are always loaded in IDLE before use, so they carry no reset.
   always_ff @(posedge clock) begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      bmag_q    <= bmag_d;
      a_q       <= a_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      bzero_q   <= bzero_d;
   end

   assign div_if.LO   = lo_q;
   assign div_if.HI   = hi_q;
   assign div_if.busy = busy_q;
   assign div_if.done = done_q;
`ifdef ALU_DIV_ZERO_FLAG_EN
   assign div_if.div_zero = dz_q;
`endif

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq (builds with or without ALU_DIV_ZERO_FLAG_EN).
module tb_alu_div_seq;

   localparam int WIDTH = 32;
`ifdef ALU_DIV_ZERO_FLAG_EN
   localparam int DZ_EDGES = 2;
   localparam int DZ_BUSY  = 1;
`else
   localparam int DZ_EDGES = 34;
   localparam int DZ_BUSY  = 33;
`endif

   logic clock = 1'b0;
   logic clear;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clock = ~clock;

   alu_div_seq_if #(.WIDTH(WIDTH)) div_if ();

   alu_div_seq #(.WIDTH(WIDTH)) dut (
      .clock  (clock),
      .clear  (clear),
      .div_if (div_if)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Called just after a rising edge; returns just after the edge that raised done.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int inject,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output int edges, output int busy_cyc, output logic dz);
      div_if.start = 1'b1;
      div_if.A     = a;
      div_if.B     = b;
      @(posedge clock);
      #1;
      div_if.start = 1'b0;
      div_if.A     = 32'h0000_5A5A;
      div_if.B     = 32'h0000_0003;
      edges        = 1;
      busy_cyc     = div_if.busy ? 1 : 0;
      while (!div_if.done && edges < 100) begin
         if (edges == inject) begin
            div_if.start = 1'b1;
            div_if.A     = 32'd999;
            div_if.B     = 32'd3;
         end else begin
            div_if.start = 1'b0;
         end
         @(posedge clock);
         #1;
         edges++;
         if (div_if.busy) busy_cyc++;
      end
      div_if.start = 1'b0;
      chk("done_seen", div_if.done, 1'b1);
      lo = div_if.LO;
      hi = div_if.HI;
`ifdef ALU_DIV_ZERO_FLAG_EN
      dz = div_if.div_zero;
`else
      dz = 1'b0;
`endif
   endtask

   logic [31:0] lo, hi;
   int          edges, bcyc, dcount;
   logic        dz;

   initial begin
      clear        = 1'b0;
      div_if.start = 1'b0;
      div_if.A     = '0;
      div_if.B     = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_lo", div_if.LO, 32'd0);
      chk("rst_hi", div_if.HI, 32'd0);
      chk("rst_busy", div_if.busy, 1'b0);
      chk("rst_done", div_if.done, 1'b0);
      clear = 1'b1;
      @(posedge clock);
      #1;

      // 100 / 7 with latency and busy length
      do_op(32'd100, 32'd7, 0, lo, hi, edges, bcyc, dz);
      chk("t1_lo", lo, 32'd14);
      chk("t1_hi", hi, 32'd2);
      chk("t1_edges", edges, 34);
      chk("t1_busy", bcyc, 33);
      @(posedge clock);
      #1;
      chk("t1_done_pulse", div_if.done, 1'b0);
      chk("t1_lo_hold", div_if.LO, 32'd14);

      // sign combinations, issued back-to-back in each done cycle
      do_op(32'hFFFF_FF9C, 32'd7, 0, lo, hi, edges, bcyc, dz);
      chk("t2a_lo", lo, 32'hFFFF_FFF2);
      chk("t2a_hi", hi, 32'hFFFF_FFFE);
      do_op(32'd100, 32'hFFFF_FFF9, 0, lo, hi, edges, bcyc, dz);
      chk("t2b_lo", lo, 32'hFFFF_FFF2);
      chk("t2b_hi", hi, 32'd2);
      chk("t2b_b2b_edges", edges, 34);
      do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, lo, hi, edges, bcyc, dz);
      chk("t2c_lo", lo, 32'd14);
      chk("t2c_hi", hi, 32'hFFFF_FFFE);

      // overflow wrap and small quotient
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 0, lo, hi, edges, bcyc, dz);
      chk("t3a_lo", lo, 32'h8000_0000);
      chk("t3a_hi", hi, 32'd0);
      do_op(32'd5, 32'd9, 0, lo, hi, edges, bcyc, dz);
      chk("t3b_lo", lo, 32'd0);
      chk("t3b_hi", hi, 32'd5);

      // divide by zero
      do_op(32'h0000_1234, 32'd0, 0, lo, hi, edges, bcyc, dz);
      chk("t4_lo", lo, 32'hFFFF_FFFF);
      chk("t4_hi", hi, 32'h0000_1234);
      chk("t4_edges", edges, DZ_EDGES);
      chk("t4_busy", bcyc, DZ_BUSY);
`ifdef ALU_DIV_ZERO_FLAG_EN
      chk("t4_dz", dz, 1'b1);
      @(posedge clock);
      #1;
      chk("t4_dz_hold", div_if.div_zero, 1'b1);
`else
      @(posedge clock);
      #1;
`endif

      // start pulsed mid-RUN is ignored
      do_op(32'd100, 32'd7, 11, lo, hi, edges, bcyc, dz);
      chk("t5_lo", lo, 32'd14);
      chk("t5_hi", hi, 32'd2);
      chk("t5_edges", edges, 34);
`ifdef ALU_DIV_ZERO_FLAG_EN
      chk("t5_dz_clr", dz, 1'b0);
`endif
      @(posedge clock);
      #1;
      chk("t5_no_retrigger", div_if.busy, 1'b0);

      // asynchronous clear mid-operation
      div_if.start = 1'b1;
      div_if.A     = 32'd200;
      div_if.B     = 32'd3;
      @(posedge clock);
      #1;
      div_if.start = 1'b0;
      repeat (15) @(posedge clock);
      #2;
      clear = 1'b0;
      #1;
      chk("t6_lo", div_if.LO, 32'd0);
      chk("t6_hi", div_if.HI, 32'd0);
      chk("t6_busy", div_if.busy, 1'b0);
      chk("t6_done", div_if.done, 1'b0);
      dcount = 0;
      repeat (3) begin
         @(posedge clock);
         #1;
         if (div_if.done) dcount++;
      end
      clear = 1'b1;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (div_if.done) dcount++;
      end
      chk("t6_no_done", dcount, 0);
      do_op(32'd100, 32'd7, 0, lo, hi, edges, bcyc, dz);
      chk("t6_lo_after", lo, 32'd14);
      chk("t6_hi_after", hi, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
